// File: rtl/scoreboard.sv
// Circular in-order scoreboard between decode (writer) and commit (reader).
// Decode pushes entries tagged with a trans_id equal to the issue pointer.
// Functional units write results back out of order by trans_id.
// Commit pops entries strictly in program order once their result is valid.
// Optional feature: define SB_FORWARD_EN to add the rs1/rs2 operand-forwarding lookup ports.

package scoreboard_pkg;
  parameter int unsigned NR_SB_ENTRIES = 4;
  parameter int unsigned NR_WB_PORTS   = 3;
  parameter int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    exception_t               ex;
  } scoreboard_entry_t;

  parameter int unsigned EX_W       = $bits(exception_t);
  parameter int unsigned SB_ENTRY_W = $bits(scoreboard_entry_t);
endpackage

module scoreboard #(
  parameter int unsigned NR_ENTRIES  = scoreboard_pkg::NR_SB_ENTRIES,
  parameter int unsigned NR_WB_PORTS = scoreboard_pkg::NR_WB_PORTS
) (
  input  logic                                                     clk_i,
  input  logic                                                     rst_i,
  input  logic                                                     flush_i,
  output logic                                                     full_o,
`ifdef SB_FORWARD_EN
  input  logic [4:0]                                               rs1_i,
  input  logic [4:0]                                               rs2_i,
  output logic [63:0]                                              rs1_o,
  output logic [63:0]                                              rs2_o,
  output logic                                                     rs1_valid_o,
  output logic                                                     rs2_valid_o,
  output logic                                                     rs1_busy_o,
  output logic                                                     rs2_busy_o,
`endif
  input  logic [scoreboard_pkg::SB_ENTRY_W-1:0]                    decoded_instr_i,
  input  logic                                                     decoded_instr_valid_i,
  output logic                                                     decoded_instr_ack_o,
  output logic [scoreboard_pkg::TRANS_ID_BITS-1:0]                 issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0][scoreboard_pkg::TRANS_ID_BITS-1:0] trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]                             wdata_i,
  input  logic [NR_WB_PORTS-1:0]                                   wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][scoreboard_pkg::EX_W-1:0]         ex_i,
  output logic [scoreboard_pkg::SB_ENTRY_W-1:0]                    commit_instr_o,
  output logic                                                     commit_valid_o,
  input  logic                                                     commit_ack_i
);

  typedef scoreboard_pkg::scoreboard_entry_t entry_t;
  typedef scoreboard_pkg::exception_t        exc_t;

  // Pointers are exactly trans_id wide so they wrap naturally at NR_ENTRIES.
  localparam int unsigned IdW  = scoreboard_pkg::TRANS_ID_BITS;
  localparam int unsigned CntW = IdW + 1;

  entry_t                mem_q [NR_ENTRIES];
  entry_t                mem_d [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] occupied_q, occupied_d;
  logic [IdW-1:0]        issue_ptr_q, issue_ptr_d;
  logic [IdW-1:0]        commit_ptr_q, commit_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  enq, deq;
  exc_t                  wb_exc;

  // Handshakes are derived from registered state only; no commit-to-enqueue bypass.
  assign full_o              = (count_q == CntW'(NR_ENTRIES));
  assign decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i;
  assign issue_trans_id_o    = issue_ptr_q;
  assign commit_instr_o      = mem_q[commit_ptr_q];
  assign commit_valid_o      = (count_q != '0) & mem_q[commit_ptr_q].valid;
  assign enq                 = decoded_instr_ack_o;
  assign deq                 = commit_ack_i & commit_valid_o & ~flush_i;

  // Next-state: writeback, then commit, then enqueue; flush overrides everything.
  always_comb begin
    mem_d        = mem_q;
    occupied_d   = occupied_q;
    issue_ptr_d  = issue_ptr_q;
    commit_ptr_d = commit_ptr_q;
    count_d      = count_q;
    wb_exc       = '0;

    if (flush_i) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        mem_d[i] = '0;
      end
      occupied_d   = '0;
      issue_ptr_d  = '0;
      commit_ptr_d = '0;
      count_d      = '0;
    end else begin
      // Ascending port order lets the highest port index win on a slot collision.
      for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
        if (wb_valid_i[p] && occupied_q[trans_id_i[p]]) begin
          wb_exc                        = ex_i[p];
          mem_d[trans_id_i[p]].result   = wdata_i[p];
          mem_d[trans_id_i[p]].valid    = 1'b1;
          if (wb_exc.valid) begin
            mem_d[trans_id_i[p]].ex = wb_exc;
          end
        end
      end

      if (deq) begin
        occupied_d[commit_ptr_q]  = 1'b0;
        mem_d[commit_ptr_q].valid = 1'b0;
        commit_ptr_d              = commit_ptr_q + 1'b1;
      end

      // The issue slot is never occupied when enq is high, so no writeback can race it.
      if (enq) begin
        mem_d[issue_ptr_q]          = decoded_instr_i;
        mem_d[issue_ptr_q].trans_id = issue_ptr_q;
        mem_d[issue_ptr_q].valid    = mem_d[issue_ptr_q].ex.valid;
        occupied_d[issue_ptr_q]     = 1'b1;
        issue_ptr_d                 = issue_ptr_q + 1'b1;
      end

      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
      occupied_q   <= '0;
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
    end else begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        mem_q[i] <= mem_d[i];
      end
      occupied_q   <= occupied_d;
      issue_ptr_q  <= issue_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      count_q      <= count_d;
    end
  end

`ifdef SB_FORWARD_EN
  logic [IdW-1:0] fwd_idx;

  // Walk from oldest to youngest so the last match is the nearest producer before issue_ptr.
  always_comb begin
    rs1_o       = '0;
    rs2_o       = '0;
    rs1_valid_o = 1'b0;
    rs2_valid_o = 1'b0;
    rs1_busy_o  = 1'b0;
    rs2_busy_o  = 1'b0;
    fwd_idx     = '0;
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      fwd_idx = commit_ptr_q + IdW'(i);
      if ((CntW'(i) < count_q) && occupied_q[fwd_idx]) begin
        if ((rs1_i != 5'd0) && (mem_q[fwd_idx].rd == rs1_i)) begin
          rs1_valid_o = mem_q[fwd_idx].valid;
          rs1_busy_o  = ~mem_q[fwd_idx].valid;
          rs1_o       = mem_q[fwd_idx].valid ? mem_q[fwd_idx].result : '0;
        end
        if ((rs2_i != 5'd0) && (mem_q[fwd_idx].rd == rs2_i)) begin
          rs2_valid_o = mem_q[fwd_idx].valid;
          rs2_busy_o  = ~mem_q[fwd_idx].valid;
          rs2_o       = mem_q[fwd_idx].valid ? mem_q[fwd_idx].result : '0;
        end
      end
    end
  end
`endif

endmodule
